// File: rtl/pkt_pkg.sv
// Shared types and constants for the ciphertext packetizer.
// Holds the output FSM encoding, header width and checksum seed.
package pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_CHK  = 2'd3
    } pkt_state_e;

    localparam int          HDR_W    = 8;
    localparam logic [7:0]  CHK_SEED = 8'h00;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; zero-latency head, push ignored when full.
// Full/empty come from the registered occupancy, so a same-cycle pop never frees room for a push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/ctxt_packetizer.sv
// Groups the unthrottled ciphertext byte stream into length-prefixed frames on a ready/valid port;
// header valid 2 cycles after close, drops+flags bytes when full; PKT_CHECKSUM_EN appends an XOR byte.
module ctxt_packetizer
    import pkt_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ctxt_char,
    input  logic             ctxt_valid,
    input  logic             flush,
    output logic [HDR_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             overflow
);
    logic             pay_push, pay_pop, pay_full, pay_empty;
    logic [7:0]       pay_head;
    logic             len_push, len_pop, len_full, len_empty;
    logic [HDR_W-1:0] len_head;

    logic [8:0]       cnt_next;
    logic [7:0]       open_cnt_q, open_cnt_d;
    logic             close;
    logic             overflow_q;
    pkt_state_e       state_q, state_d;
    logic [HDR_W-1:0] rem_q, rem_d;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]       acc_q, acc_d;
`endif

    // The byte accepted this cycle belongs to the frame it may close.
    assign pay_push   = ctxt_valid && !pay_full;
    assign cnt_next   = {1'b0, open_cnt_q} + {8'h00, pay_push};
    assign close      = (cnt_next == 9'(FRAME_LEN)) || (flush && (cnt_next != 9'd0));
    assign len_push   = close && !len_full;
    assign open_cnt_d = close ? 8'h00 : cnt_next[7:0];
    assign overflow   = overflow_q;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_pay_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (pay_push),
        .wr_data_i (ctxt_char),
        .pop_i     (pay_pop),
        .rd_data_o (pay_head),
        .full_o    (pay_full),
        .empty_o   (pay_empty)
    );

    sync_fifo #(.WIDTH(HDR_W), .DEPTH(DEPTH)) u_len_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (len_push),
        .wr_data_i (cnt_next[HDR_W-1:0]),
        .pop_i     (len_pop),
        .rd_data_o (len_head),
        .full_o    (len_full),
        .empty_o   (len_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            open_cnt_q <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            rem_q      <= '0;
`ifdef PKT_CHECKSUM_EN
            acc_q      <= CHK_SEED;
`endif
        end else begin
            open_cnt_q <= open_cnt_d;
            if (ctxt_valid && pay_full) overflow_q <= 1'b1;
            state_q    <= state_d;
            rem_q      <= rem_d;
`ifdef PKT_CHECKSUM_EN
            acc_q      <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        len_pop   = 1'b0;
        pay_pop   = 1'b0;
`ifdef PKT_CHECKSUM_EN
        acc_d     = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!len_empty) begin
                    state_d = ST_HDR;
                    rem_d   = len_head;
                end
            end
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = rem_q;
`ifdef PKT_CHECKSUM_EN
                acc_d     = CHK_SEED;
`endif
                if (out_ready) begin
                    len_pop = 1'b1;
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                out_valid = !pay_empty;
                out_data  = pay_head;
`ifndef PKT_CHECKSUM_EN
                out_last  = (rem_q == 8'd1);
`endif
                if (out_valid && out_ready) begin
                    pay_pop = 1'b1;
                    rem_d   = rem_q - 8'd1;
`ifdef PKT_CHECKSUM_EN
                    acc_d   = acc_q ^ pay_head;
                    if (rem_q == 8'd1) state_d = ST_CHK;
`else
                    // Chain straight into the next queued header so frames stay gapless.
                    if (rem_q == 8'd1) begin
                        state_d = len_empty ? ST_IDLE : ST_HDR;
                        rem_d   = len_head;
                    end
`endif
                end
            end
`ifdef PKT_CHECKSUM_EN
            ST_CHK: begin
                out_valid = 1'b1;
                out_data  = acc_q;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = len_empty ? ST_IDLE : ST_HDR;
                    rem_d   = len_head;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/ctxt_packetizer.md
Name: ctxt_packetizer

Overview:
- Downstream stage of the stream cipher. Consumes the cipher's per-cycle ciphertext byte strobe, which has no backpressure.
- Buffers the bytes in a FIFO and groups them into length-prefixed frames.
- Emits the frames on a ready/valid byte interface to the transport/UART side.
- Absorbs consumer stalls. Bytes that arrive while the FIFO is full are dropped and flagged.

Parameters:
- DEPTH, 16: payload FIFO entries. Power of 2, at least 2.
- FRAME_LEN, 8: maximum payload bytes per frame. Range 1..255 and FRAME_LEN <= DEPTH.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ctxt_char  in  8  ciphertext byte, connected to the cipher's ctxt_char.
- ctxt_valid  in  1  one byte per cycle while high, connected to the cipher's dout_valid.
- flush  in  1  single-cycle pulse; closes the open frame early.
- out_data  out  8  frame byte: header or payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- out_last  out  1  marks the final byte of the frame.
- overflow  out  1  sticky; set when any byte is dropped.

Behaviour:
- Reset is synchronous, active-high, and identical mid-frame. All partial frames and FIFO contents are discarded.
  - Reset values: out_valid=0, out_last=0, out_data=8'h00, overflow=0.
  - Internal state after reset: FIFOs empty, open-frame count=0, output FSM in IDLE.
- Input side:
  - Push when ctxt_valid and the data FIFO is not full.
  - Full is evaluated on the registered occupancy before any same-cycle pop. A byte arriving when full is dropped even if a pop occurs that cycle. The drop sets overflow and the byte is not counted.
  - open_cnt (8 bit) counts bytes pushed into the current open frame.
- Frame close: occurs at an edge when either condition holds:
  - (a) open_cnt plus the byte accepted this cycle reaches FRAME_LEN; or
  - (b) flush=1 and open_cnt plus the byte accepted this cycle is at least 1.
- On close:
  - The final length L (1..FRAME_LEN) is pushed to the length FIFO (depth DEPTH, so it can never overflow).
  - open_cnt is cleared to 0.
  - Flush together with a byte: the byte belongs to the closing frame. Flush together with a length-reaching byte: a single close.
  - Flush with an empty open frame is ignored.
- Output FSM states: IDLE, HDR, PAY.
  - IDLE -> HDR when the length FIFO is non-empty. The length is registered into rem and out_valid rises in the following cycle, giving 2 cycles from close to header valid.
  - HDR: out_data=L, out_last=0. On handshake, pop the length entry and go to PAY.
  - PAY: out_data is the FIFO head. out_last=1 when rem==1. On handshake, pop and decrement rem.
    - When the last byte is accepted: go to HDR if another length is queued, else IDLE. No bubble is inserted between frames.
- out_data and out_valid are held stable while out_valid && !out_ready.
- Only closed frames are ever emitted. An open frame waits for FRAME_LEN bytes or a flush.
- Concurrent push and pop are both honoured when not full. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: PKT_CHECKSUM_EN.
- When defined:
  - PAY is followed by a CHK state emitting the XOR of all L payload bytes. The accumulator clears on entry to HDR.
  - out_last moves from the final payload byte to the checksum byte.
  - The header value remains L and does not count the checksum byte.
- When undefined: no CHK state and no accumulator. out_last is on the final payload byte.

Decomposition:
- Shared package pkt_pkg holds:
  - the enum typedef for the output FSM state (IDLE/HDR/PAY/CHK);
  - localparams for the header byte width and the checksum seed 8'h00.
- One sub-module, sync_fifo (parameterised WIDTH, DEPTH, with full/empty flags), instantiated twice:
  - 8-bit payload FIFO;
  - 8-bit length FIFO.

Test Plan:
- Full frame, consumer always ready: bytes 01..08 on 8 consecutive ctxt_valid cycles with out_ready=1. Required output: 08,01..08 with out_last on 08. Header valid 2 cycles after the 8th byte's edge.
- Flush, partial frame: bytes AA,BB, then a flush pulse. Required output: 02,AA,BB with out_last on BB. A flush with no pending bytes produces no output.
- Flush concurrent with a byte: bytes 11,22 and flush asserted in the same cycle as 22. Required output: a single frame 02,11,22.
- Backpressure and overflow (DEPTH=16, FRAME_LEN=8), out_ready=0:
  - 20 bytes 00..13 are fed. Bytes 10..13 are dropped and overflow=1 from the first drop.
  - With out_ready then asserted, the required output is 08,00..07,08,08..0F.
  - out_data is stable during the stall.
- Back-to-back frames with random out_ready toggling over 24 bytes: output matches the reference queue, with no bubble between the last byte of one frame and the next header when ready.
- Mid-frame reset: rst asserted during PAY. Next cycle out_valid=0 and overflow=0. Frames sent after reset are correct.
- With PKT_CHECKSUM_EN defined: bytes 01,02,04 then flush. Required output: 03,01,02,04,07 with out_last on 07.
